// File: rtl/rans_enc_ctrl.sv
// rANS encoder sequencer: loads the core frequency table (cumulative sums
// computed on the fly), issues a counted symbol run, and buffers core output
// bytes in a FIFO guarded by credits since the core pipeline cannot stall.
module rans_enc_ctrl #(
   parameter int unsigned RESOLUTION   = 10,
   parameter int unsigned SYMBOL_WIDTH = 8,
   parameter int unsigned CNT_WIDTH    = 16,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic                    load_i,
   input  logic [CNT_WIDTH-1:0]    nsym_i,
   input  logic                    freq_valid_i,
   output logic                    freq_ready_o,
   input  logic [RESOLUTION-1:0]   freq_i,
   input  logic                    sym_valid_i,
   output logic                    sym_ready_o,
   input  logic [SYMBOL_WIDTH-1:0] sym_i,
   output logic                    enc_en_o,
   output logic                    enc_freq_wr_o,
   output logic [RESOLUTION-1:0]   enc_freq_o,
   output logic [RESOLUTION-1:0]   enc_cum_o,
   output logic [SYMBOL_WIDTH-1:0] enc_symb_o,
   input  logic                    enc_valid_i,
   input  logic [SYMBOL_WIDTH-1:0] enc_byte_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [SYMBOL_WIDTH-1:0] out_byte_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [1:0]              err_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;   // FIFO count 0..FIFO_DEPTH
   localparam int unsigned OW = CW + 1;   // count + inflight headroom

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ENCODE, S_DRAIN, S_DONE} state_e;

   state_e                  state_q, state_d;
   logic [SYMBOL_WIDTH-1:0] idx_q, idx_d;
   logic [RESOLUTION:0]     cum_q, cum_d, cum_next;
   logic [CNT_WIDTH-1:0]    rem_q, rem_d;
   logic [2:0]              issued_q, issued_d;
   logic                    table_ok_q, table_ok_d;
   logic [1:0]              err_q, err_d;

   logic [SYMBOL_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]           wr_q, rd_q;
   logic [CW-1:0]           cnt_q;

   logic          freq_acc, sym_acc, credit_ok, fifo_full, push, pop, ovf;
   logic [OW-1:0] occupancy;

   // Handshakes, credit and FIFO push/pop qualification
   always_comb begin
      freq_acc  = (state_q == S_LOAD) && freq_valid_i;
      cum_next  = cum_q + (RESOLUTION+1)'(freq_i);
      occupancy = OW'(cnt_q) + OW'(issued_q[0]) + OW'(issued_q[1]) + OW'(issued_q[2]);
      credit_ok = occupancy < OW'(FIFO_DEPTH);
      sym_ready_o = (state_q == S_ENCODE) && (rem_q != '0) && credit_ok;
      sym_acc   = sym_ready_o && sym_valid_i;
      fifo_full = cnt_q == CW'(FIFO_DEPTH);
      pop       = (cnt_q != '0) && out_ready_i;
      push      = enc_valid_i && (!fifo_full || pop);
      ovf       = enc_valid_i && fifo_full && !pop;
   end

   // Core-facing and status outputs decoded from state and live handshakes
   always_comb begin
      freq_ready_o  = state_q == S_LOAD;
      enc_freq_wr_o = freq_acc;
      enc_freq_o    = freq_acc ? freq_i : '0;
      enc_cum_o     = freq_acc ? cum_q[RESOLUTION-1:0] : '0;
      enc_en_o      = sym_acc;
      enc_symb_o    = freq_acc ? idx_q : (sym_acc ? sym_i : '0);
      out_valid_o   = cnt_q != '0;
      out_byte_o    = out_valid_o ? mem_q[rd_q] : '0;
      busy_o        = state_q != S_IDLE;
      done_o        = state_q == S_DONE;
      err_o         = err_q;
   end

   // Next-state logic for sequencer, table loader and run counter
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cum_d      = cum_q;
      rem_d      = rem_q;
      table_ok_d = table_ok_q;
      err_d      = err_q;
      issued_d   = {issued_q[1:0], sym_acc};
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               err_d = 2'd0;
               rem_d = nsym_i;
               if (load_i) begin
                  state_d    = S_LOAD;
                  idx_d      = '0;
                  cum_d      = '0;
                  table_ok_d = 1'b0;
               end else if (table_ok_q) begin
                  state_d = S_ENCODE;
               end else begin
                  err_d   = 2'd2;
                  state_d = S_DONE;
               end
            end
         end
         S_LOAD: begin
            if (freq_acc) begin
               if (idx_q == '1) begin
                  if (cum_next == (RESOLUTION+1)'(2**RESOLUTION)) begin
                     table_ok_d = 1'b1;
                     state_d    = S_ENCODE;
                  end else begin
                     table_ok_d = 1'b0;
                     err_d      = 2'd1;
                     state_d    = S_DONE;
                  end
               end else begin
                  idx_d = idx_q + SYMBOL_WIDTH'(1);
                  cum_d = cum_next;
               end
            end
         end
         S_ENCODE: begin
            if (rem_q == '0) state_d = S_DRAIN;
            else if (sym_acc) rem_d = rem_q - CNT_WIDTH'(1);
         end
         S_DRAIN: begin
            if (issued_q == '0) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      // A dropped byte is the most severe fault, so it wins
      if (ovf) err_d = 2'd3;
   end

   // Sequencer state registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         cum_q      <= '0;
         rem_q      <= '0;
         issued_q   <= '0;
         table_ok_q <= 1'b0;
         err_q      <= 2'd0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cum_q      <= cum_d;
         rem_q      <= rem_d;
         issued_q   <= issued_d;
         table_ok_q <= table_ok_d;
         err_q      <= err_d;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + AW'(1);
         if (pop)  rd_q <= rd_q + AW'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // FIFO storage, contents are don't-care until pushed
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_q] <= enc_byte_i;
   end

endmodule

// File: tb/tb_rans_enc_ctrl.sv
// Directed bench for rans_enc_ctrl with a 3-cycle core pipeline model.
module tb_rans_enc_ctrl;
   localparam int unsigned RES = 10;
   localparam int unsigned SW  = 8;
   localparam int unsigned CNW = 16;

   logic           clk_i = 1'b0;
   logic           rst_i = 1'b1;
   logic           start_i = 1'b0, load_i = 1'b0;
   logic [CNW-1:0] nsym_i = '0;
   logic           freq_valid_i = 1'b0, freq_ready_o;
   logic [RES-1:0] freq_i = '0;
   logic           sym_valid_i = 1'b1, sym_ready_o;
   logic [SW-1:0]  sym_i = '0;
   logic           enc_en_o, enc_freq_wr_o;
   logic [RES-1:0] enc_freq_o, enc_cum_o;
   logic [SW-1:0]  enc_symb_o;
   logic           enc_valid_i;
   logic [SW-1:0]  enc_byte_i;
   logic           out_valid_o, out_ready_i = 1'b1;
   logic [SW-1:0]  out_byte_o;
   logic           busy_o, done_o;
   logic [1:0]     err_o;

   always #5 clk_i = ~clk_i;

   rans_enc_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .load_i(load_i), .nsym_i(nsym_i),
      .freq_valid_i(freq_valid_i), .freq_ready_o(freq_ready_o), .freq_i(freq_i),
      .sym_valid_i(sym_valid_i), .sym_ready_o(sym_ready_o), .sym_i(sym_i),
      .enc_en_o(enc_en_o), .enc_freq_wr_o(enc_freq_wr_o), .enc_freq_o(enc_freq_o),
      .enc_cum_o(enc_cum_o), .enc_symb_o(enc_symb_o), .enc_valid_i(enc_valid_i),
      .enc_byte_i(enc_byte_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_byte_o(out_byte_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   // Core model: byte = symbol ^ 0x5A, valid three cycles after enc_en_o
   logic [2:0]    pv = 3'b000;
   logic [SW-1:0] ps0 = '0, ps1 = '0, ps2 = '0;
   logic          inject = 1'b0;
   always @(posedge clk_i) begin
      pv  <= {pv[1:0], enc_en_o};
      ps0 <= enc_symb_o;
      ps1 <= ps0;
      ps2 <= ps1;
   end
   assign enc_valid_i = pv[2] | inject;
   assign enc_byte_i  = ps2 ^ 8'h5A;

   int checks = 0, errors = 0;
   int en_cnt = 0, done_cnt = 0, byte_err = 0;
   logic [SW-1:0] exp_q[$];

   // Monitor: issue/done counting and output byte scoreboard
   always @(negedge clk_i) begin
      if (enc_en_o) begin
         en_cnt++;
         exp_q.push_back(enc_symb_o ^ 8'h5A);
      end
      if (done_o) done_cnt++;
      if (out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) byte_err++;
         else begin
            if (out_byte_o !== exp_q[0]) byte_err++;
            void'(exp_q.pop_front());
         end
      end
   end

   // Symbol source: always valid, advances on acceptance
   initial begin
      logic acc;
      forever begin
         @(negedge clk_i);
         acc = sym_valid_i && sym_ready_o;
         @(posedge clk_i);
         #1;
         if (acc) sym_i = sym_i + 8'd7;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_start(input logic ld, input int n);
      start_i = 1'b1;
      load_i  = ld;
      nsym_i  = n[15:0];
      tick();
      start_i = 1'b0;
      load_i  = 1'b0;
   endtask

   function automatic int fval(input int mode, input int i);
      case (mode)
         1:       return (i == 255) ? 3 : 4;     // sums to 1023
         2:       return (i == 0) ? 769 : 1;     // skewed, sums to 1024
         default: return 4;                       // uniform
      endcase
   endfunction

   // Feeds 256 freq words, counting any wrong core write beats
   task automatic load_table(input int mode, output int werr);
      int   cum;
      logic got;
      cum  = 0;
      werr = 0;
      for (int i = 0; i < 256; i++) begin
         freq_valid_i = 1'b1;
         freq_i       = RES'(fval(mode, i));
         got          = 1'b0;
         for (int b = 0; b < 20 && !got; b++) begin
            @(negedge clk_i);
            if (freq_ready_o) begin
               got = 1'b1;
               if (enc_cum_o !== cum[9:0] || enc_symb_o !== i[7:0] ||
                   enc_freq_wr_o !== 1'b1 || enc_freq_o !== freq_i) werr++;
            end
            tick();
         end
         if (!got) werr++;
         cum += fval(mode, i);
      end
      freq_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cycles, output logic seen);
      int d0;
      d0     = done_cnt;
      seen   = 1'b0;
      cycles = 0;
      while (!seen && cycles < budget) begin
         tick();
         cycles++;
         if (done_cnt > d0) seen = 1'b1;
      end
   endtask

   task automatic drain(input string name);
      int b;
      b = 0;
      out_ready_i = 1'b1;
      while ((out_valid_o || exp_q.size() != 0) && b < 200) begin
         tick();
         b++;
      end
      check({name, "_drained"}, exp_q.size(), 0);
      check({name, "_bytes"}, byte_err, 0);
   endtask

   typedef struct {
      logic ld;
      int   mode;
      int   nsym;
      int   exp_err;
      int   exp_en;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int   werr, cyc, e0;
      logic seen;

      vecs[0] = '{1'b1, 0, 0,   0, 0};
      vecs[1] = '{1'b0, 0, 100, 0, 100};
      vecs[2] = '{1'b1, 1, 5,   1, 0};
      vecs[3] = '{1'b0, 0, 5,   2, 0};
      vecs[4] = '{1'b1, 2, 10,  0, 10};
      vecs[5] = '{1'b0, 0, 3,   0, 3};

      // Reset values
      #12;
      check("rst_err", err_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_outv", out_valid_o, 0);
      check("rst_ready", {30'd0, freq_ready_o, sym_ready_o}, 0);
      repeat (3) tick();
      rst_i = 1'b0;
      tick();

      for (int v = 0; v < 6; v++) begin
         e0 = en_cnt;
         do_start(vecs[v].ld, vecs[v].nsym);
         if (vecs[v].ld) begin
            load_table(vecs[v].mode, werr);
            check($sformatf("v%0d_loadbeats", v), werr, 0);
         end
         wait_done(2000, cyc, seen);
         check($sformatf("v%0d_done", v), seen, 1);
         check($sformatf("v%0d_pipe_empty", v), pv, 0);
         check($sformatf("v%0d_err", v), err_o, vecs[v].exp_err);
         check($sformatf("v%0d_issues", v), en_cnt - e0, vecs[v].exp_en);
         drain($sformatf("v%0d", v));
         check($sformatf("v%0d_idle", v), busy_o, 0);
      end

      // nsym=0: short pass, no issue
      e0 = en_cnt;
      do_start(1'b0, 0);
      wait_done(10, cyc, seen);
      check("n0_latency", seen && cyc <= 4, 1);
      check("n0_issues", en_cnt - e0, 0);

      // Backpressure: issue halts at 8 outstanding bytes, resumes on pop
      out_ready_i = 1'b0;
      e0 = en_cnt;
      do_start(1'b0, 20);
      repeat (40) tick();
      check("bp_stalled_issues", en_cnt - e0, 8);
      check("bp_sym_ready", sym_ready_o, 0);
      check("bp_outv", out_valid_o, 1);
      check("bp_err", err_o, 0);
      out_ready_i = 1'b1;
      wait_done(500, cyc, seen);
      check("bp_done", seen, 1);
      check("bp_issues", en_cnt - e0, 20);
      check("bp_err_end", err_o, 0);
      drain("bp");

      // Overflow: full FIFO and a spurious core byte
      out_ready_i = 1'b0;
      do_start(1'b0, 8);
      wait_done(200, cyc, seen);
      check("ovf_run_err", err_o, 0);
      inject = 1'b1;
      tick();
      inject = 1'b0;
      tick();
      check("ovf_err", err_o, 3);
      drain("ovf");

      // Asynchronous reset in the middle of ENCODE
      do_start(1'b0, 100);
      repeat (20) tick();
      #2 rst_i = 1'b1;
      #1;
      check("arst_busy", busy_o, 0);
      check("arst_outs", {28'd0, sym_ready_o, enc_en_o, out_valid_o, done_o}, 0);
      check("arst_err", err_o, 0);
      repeat (5) tick();
      exp_q.delete();
      rst_i = 1'b0;
      tick();
      e0 = en_cnt;
      do_start(1'b0, 5);
      wait_done(20, cyc, seen);
      check("arst_done", seen, 1);
      check("arst_notable", err_o, 2);
      check("arst_issues", en_cnt - e0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
